// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Each access takes IDLE -> SERVE (one-cycle strobe) -> DONE (ack pulse).
module mem_access_arbiter #(
  parameter int n       = 64,
  parameter int LogSize = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         we0,
  input  logic [n-1:0] addr0,
  input  logic [n-1:0] wdata0,
  output logic         ack0,
  output logic [n-1:0] rdata0,
  output logic         err0,
  input  logic         req1,
  input  logic         we1,
  input  logic [n-1:0] addr1,
  input  logic [n-1:0] wdata1,
  output logic         ack1,
  output logic [n-1:0] rdata1,
  output logic         err1,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_din,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [n-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_e;

  state_e       state_q;
  logic         last_grant_q, cur_id_q, cur_we_q, oor_q;
  logic [n-1:0] mem_addr_q, mem_din_q, rdata0_q, rdata1_q;
  logic         ack0_q, ack1_q, err0_q, err1_q;

  logic         grant_d, sel_we_d, oor_d;
  logic [n-1:0] sel_addr_d, sel_wdata_d;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant_d     = (req0 & req1) ? ~last_grant_q : req1;
    sel_we_d    = grant_d ? we1 : we0;
    sel_addr_d  = grant_d ? addr1 : addr0;
    sel_wdata_d = grant_d ? wdata1 : wdata0;
    oor_d       = |sel_addr_d[n-1:LogSize];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      cur_we_q     <= 1'b0;
      oor_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            last_grant_q <= grant_d;
            cur_id_q     <= grant_d;
            cur_we_q     <= sel_we_d;
            oor_q        <= oor_d;
            mem_addr_q   <= sel_addr_d;
            mem_din_q    <= sel_wdata_d;
            state_q      <= SERVE;
          end
        end
        SERVE: begin
          // Out-of-range clears rdata; an in-range write leaves it untouched.
          if (cur_id_q) begin
            ack1_q <= 1'b1;
            err1_q <= oor_q;
            if (oor_q)          rdata1_q <= '0;
            else if (!cur_we_q) rdata1_q <= mem_dout;
          end else begin
            ack0_q <= 1'b1;
            err0_q <= oor_q;
            if (oor_q)          rdata0_q <= '0;
            else if (!cur_we_q) rdata0_q <= mem_dout;
          end
          state_q <= DONE;
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset kills them mid-cycle.
  assign mem_read  = (state_q == SERVE) & ~cur_we_q & ~oor_q;
  assign mem_write = (state_q == SERVE) &  cur_we_q & ~oor_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized + directed bench for mem_access_arbiter against a transaction-level
// reference: round-robin schedule on a cycle timeline and a shadow memory.
module tb_mem_access_arbiter;
  localparam int N     = 64;
  localparam int LS    = 10;
  localparam int DEPTH = 1 << LS;

  logic         clk = 1'b0, reset = 1'b0;
  logic         req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [N-1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic         ack0, err0, ack1, err1, mem_read, mem_write;
  logic [N-1:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_access_arbiter #(.n(N), .LogSize(LS)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  // Memory device the DUT talks to
  logic [N-1:0] dev_mem [DEPTH];
  always @(posedge clk) if (mem_write) dev_mem[mem_addr[LS-1:0]] <= mem_din;
  assign mem_dout = mem_read ? dev_mem[mem_addr[LS-1:0]] : '0;

  // Reference model state
  logic [N-1:0] ref_mem [DEPTH];
  logic [N-1:0] m_rd [2];
  bit           m_last;
  int           free_at;
  bit           p_vld, p_id, p_we;
  logic [N-1:0] p_addr, p_wdata;
  int           p_ack_cyc;
  bit           seen_ack0, seen_ack1;
  int           last_ack_id, last_ack_cyc;

  int checks = 0, errors = 0, cyc = 0;

  function automatic logic [N-1:0] init_val(input int i);
    return {32'hC0DE_0000, 32'(i * 7 + 3)};
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    free_at = 0;
    p_vld   = 1'b0;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask

  // One clock: predict what this edge does, then compare every output.
  task automatic step();
    bit r0, r1, w0, w1, rst_e, g_now, win, eoor;
    logic [N-1:0] a0, a1, d0, d1;
    @(posedge clk);
    r0 = req0; r1 = req1; w0 = we0; w1 = we1;
    a0 = addr0; a1 = addr1; d0 = wdata0; d1 = wdata1; rst_e = reset;
    cyc++;
    g_now = 1'b0;
    if (!rst_e && cyc >= free_at && (r0 || r1)) begin
      win       = (r0 && r1) ? !m_last : r1;
      m_last    = win;
      free_at   = cyc + 3;
      g_now     = 1'b1;
      p_vld     = 1'b1;
      p_id      = win;
      p_we      = win ? w1 : w0;
      p_addr    = win ? a1 : a0;
      p_wdata   = win ? d1 : d0;
      p_ack_cyc = cyc + 1;
    end
    #1;
    eoor = (p_addr >= 64'(DEPTH));
    chk("mem_read", mem_read, g_now && !p_we && !eoor);
    chk("mem_write", mem_write, g_now && p_we && !eoor);
    if (g_now) begin
      chk("mem_addr", mem_addr, p_addr);
      if (p_we) chk("mem_din", mem_din, p_wdata);
    end
    seen_ack0 = p_vld && cyc == p_ack_cyc && p_id == 1'b0;
    seen_ack1 = p_vld && cyc == p_ack_cyc && p_id == 1'b1;
    if (seen_ack0 || seen_ack1) begin
      if (eoor)      m_rd[p_id] = '0;
      else if (p_we) ref_mem[p_addr[LS-1:0]] = p_wdata;
      else           m_rd[p_id] = ref_mem[p_addr[LS-1:0]];
      last_ack_id  = p_id;
      last_ack_cyc = cyc;
      p_vld        = 1'b0;
    end
    chk("ack0", ack0, seen_ack0);
    chk("ack1", ack1, seen_ack1);
    chk("err0", err0, seen_ack0 && eoor);
    chk("err1", err1, seen_ack1 && eoor);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
  endtask

  // Mid-cycle reset; everything must be zero before the next edge.
  task automatic apply_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_ack0", ack0, 0);     chk("rst_ack1", ack1, 0);
    chk("rst_err0", err0, 0);     chk("rst_err1", err1, 0);
    chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
    chk("rst_maddr", mem_addr, 0); chk("rst_mdin", mem_din, 0);
    chk("rst_mrd", mem_read, 0);  chk("rst_mwr", mem_write, 0);
    model_reset();
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [N-1:0] a, input logic [N-1:0] d);
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop(input int p);
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic rand_req(input int p);
    logic [N-1:0] a;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      a = 64'(DEPTH) + 64'($urandom_range(0, 4095));
    else if (r == 1) a = {32'hFFFF_0000 | 32'($urandom_range(0, 255)), 32'($urandom_range(0, 15))};
    else             a = 64'($urandom_range(0, 15));
    set_req(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
  endtask

  task automatic run_until_ack(input int port, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if ((port == 0 && seen_ack0) || (port == 1 && seen_ack1)) got = 1;
    end
    chk("ack_seen", got, 1);
  endtask

  task automatic run_until_any_ack(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (seen_ack0 || seen_ack1) got = 1;
    end
    chk("any_ack_seen", got, 1);
  endtask

  initial begin
    int c0, prev;
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < DEPTH; i++) begin
      dev_mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    model_reset();

    // Reset then idle
    apply_reset();
    for (int i = 0; i < 10; i++) step();

    // Port 1 write then read back
    c0 = cyc;
    set_req(1, 1, 64'd5, 64'hDEAD_BEEF);
    run_until_ack(1, 10);
    chk("wr_latency", 32'(cyc - c0), 2);
    drop(1); step();
    set_req(1, 0, 64'd5, 64'd0);
    run_until_ack(1, 10);
    chk("rd5_data", rdata1, 64'hDEAD_BEEF);
    drop(1); step(); step();

    // Tie from reset: alternate 0,1,0,1 every three cycles
    set_req(0, 0, 64'd1, 64'd0);
    set_req(1, 0, 64'd2, 64'd0);
    apply_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_until_any_ack(10);
      chk("tie_order", 32'(last_ack_id), 32'(exp_order[k]));
      if (k > 0) chk("tie_gap", 32'(last_ack_cyc - prev), 3);
      prev = last_ack_cyc;
    end
    drop(0); drop(1); step(); step();

    // Port 0 held, port 1 raised during port 0's access
    set_req(0, 0, 64'd3, 64'd0);
    step();
    set_req(1, 0, 64'd4, 64'd0);
    run_until_any_ack(10);
    chk("starve_first", 32'(last_ack_id), 0);
    run_until_any_ack(10);
    chk("starve_next", 32'(last_ack_id), 1);
    drop(0); drop(1); step(); step();

    // Out-of-range and last legal address
    set_req(0, 0, 64'd1024, 64'd0);
    run_until_ack(0, 10);
    chk("oor_err", err0, 1);
    chk("oor_rdata", rdata0, 0);
    drop(0); step();
    set_req(0, 0, 64'd1023, 64'd0);
    run_until_ack(0, 10);
    chk("top_err", err0, 0);
    chk("top_rdata", rdata0, init_val(1023));
    drop(0); step(); step();

    // Reset while the write strobe is up: nothing commits, no ack
    set_req(1, 1, 64'd7, 64'h55);
    step();
    drop(1);
    apply_reset();
    step();
    set_req(1, 0, 64'd7, 64'd0);
    run_until_ack(1, 10);
    chk("rd7_after_rst", rdata1, init_val(7));
    drop(1); step(); step();

    // Random traffic; requesters hold until ack, then drop or re-request
    for (int k = 0; k < 400; k++) begin
      step();
      if (seen_ack0) begin
        if ($urandom_range(0, 1) == 1) rand_req(0); else drop(0);
      end else if (!req0 && $urandom_range(0, 2) == 0) rand_req(0);
      if (seen_ack1) begin
        if ($urandom_range(0, 1) == 1) rand_req(1); else drop(1);
      end else if (!req1 && $urandom_range(0, 2) == 0) rand_req(1);
    end
    drop(0); drop(1);
    for (int i = 0; i < 4; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is instruction fetch; requester 1 is load/store.
- Grants one access at a time round-robin, drives the memory's read/write/address/data inputs for exactly one cycle per access, and returns registered read data with an ack pulse.
- Rejects addresses outside the memory depth so no out-of-range index reaches the array.

Parameters:
- n, 64, data and address width (matches memory n)
- LogSize, 10, memory address bits; legal addresses are 0 .. 2^LogSize-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 access request; held high until ack0
- we0  input  1  requester 0 write enable (1 = write, 0 = read)
- addr0  input  n  requester 0 address
- wdata0  input  n  requester 0 write data
- ack0  output  1  one-cycle completion pulse to requester 0
- rdata0  output  n  requester 0 read data, valid while ack0=1
- err0  output  1  requester 0 out-of-range flag, valid while ack0=1
- req1, we1, addr1, wdata1, ack1, rdata1, err1  same as above, for requester 1
- mem_addr  output  n  memory Address
- mem_din  output  n  memory DataIn
- mem_read  output  1  memory memRead
- mem_write  output  1  memory memWrite
- mem_dout  input  n  memory DataOut (combinational, high-Z when memRead=0)

Behaviour:
- Reset (async, any cycle): state=IDLE; last_grant=1; all outputs 0 (ack*, err*, rdata*, mem_addr, mem_din, mem_read, mem_write).
- FSM states: IDLE, SERVE, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request present: at the posedge, latch the winner's id, we, addr and wdata into mem_addr/mem_din/cur_we/cur_id, and compute oor = |addr[n-1:LogSize]. Go to SERVE.
- Arbitration with one request: grant that request.
- Arbitration with both requests: grant the requester that is not last_grant. last_grant updates on grant, so port 0 wins the first tie after reset.
- SERVE lasts exactly 1 cycle:
  - mem_read = !cur_we & !oor.
  - mem_write = cur_we & !oor.
  - Both mem_read and mem_write are decoded from state, so they drop immediately on async reset.
- Posedge ending SERVE:
  - Memory performs the write if mem_write=1.
  - For a read, rdata[cur_id] <= mem_dout; for an oor access, rdata <= 0.
  - ack[cur_id] <= 1; err[cur_id] <= oor.
  - Next state DONE.
- DONE lasts 1 cycle:
  - ack/err/rdata visible to the requester; the requester drops or changes req at this posedge.
  - Arbiter ignores requests during DONE.
  - Next posedge: ack and err clear, rdata holds its value, state IDLE.
- Latency: req seen in IDLE cycle t → memory access in cycle t+1 → ack high in cycle t+2. Throughput is 1 access per 3 cycles.
- mem_addr and mem_din hold their last latched values outside SERVE; mem_read=mem_write=0 outside SERVE.
- Request inputs are sampled only in IDLE. Changes during SERVE or DONE do not affect the current access.
- oor access: no memory strobe, err=1, ack still given, rdata=0.
- Reset asserted during SERVE: strobes drop at once, no write commits, no ack is issued. The requester must re-request.
- Write data is never visible on rdata. For write acks, rdata keeps its previous value.

Test Plan:
- Reset then idle: assert reset mid-cycle → all outputs 0 immediately; with req0=req1=0 for 10 cycles → mem_read and mem_write never assert.
- Single write then read on port 1:
  - Write addr 5, data 0xDEAD_BEEF → mem_write=1 for exactly 1 cycle, with mem_addr=5 in that cycle; ack1 two cycles after the request.
  - Then read addr 5 → mem_read 1 cycle, ack1 with rdata1=0xDEAD_BEEF; ack0 stays 0.
- Tie and round-robin: req0 and req1 both held high from reset for 4 accesses → grant order 0,1,0,1; each ack 3 cycles apart.
- Starvation check: req0 held continuously, req1 raised late → req1 is served no later than the next grant after the current port-0 access.
- Out of range: read addr 1024 (LogSize=10) on port 0 → mem_read stays 0, ack0=1 with err0=1 and rdata0=0; then read addr 1023 → err0=0.
- Reset mid-SERVE: issue write addr 7 data 0x55, assert reset during SERVE → no ack; a subsequent read of addr 7 returns the pre-existing contents, not 0x55.
